fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Consumer at the read side of the 16x8 synchronous FIFO. It pops bytes through the FIFO's `Ren`/`Dout`/`Fempty` interface and serializes each byte as an asynchronous UART frame on `txd`. Frames are LSB first, with optional parity and 1 or 2 stop bits. It sits between the FIFO and the board serial pin and drains the FIFO whenever enabled.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 2..65535; 16-bit bit-timer.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

- `ck`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  permits starting a new fetch; does not affect a frame already in progress.
- `Fempty`  in  1  FIFO empty flag, registered by the FIFO.
- `Dout`  in  8  FIFO read data, valid from the posedge after a sampled `Ren`=1.
- `Ren`  out  1  FIFO read strobe; registered; one-cycle pulse per byte.
- `txd`  out  1  serial output; idles high; registered.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of each frame's last stop bit.

## Operation
- States: IDLE, FETCH, LATCH, START, DATA, PARITY, STOP.
- IDLE
  - `txd`=1, `Ren`=0.
  - If `en`=1 and `Fempty`=0 at an edge, go to FETCH and set `Ren`<=1.
- FETCH
  - Lasts 1 cycle, with `Ren`=1; the FIFO pops at the edge that ends this cycle.
  - Next state is LATCH, with `Ren`<=0.
- LATCH
  - Lasts 1 cycle while `Dout` settles.
  - At the exiting edge: shift register <= `Dout`, parity accumulator <= ^`Dout`, `txd`<=0, bit timer <= 0, go to START.
- START, DATA, PARITY, STOP
  - Each serial bit holds `txd` for exactly `CLKS_PER_BIT` cycles.
  - The bit timer counts 0..`CLKS_PER_BIT`-1; the bit boundary is when the timer equals `CLKS_PER_BIT`-1.
- DATA
  - 8 bits, LSB first; a 3-bit index counts 0..7.
- PARITY
  - Present only when `PARITY`!=0.
  - `txd` = accumulator for even, ~accumulator for odd.
- STOP
  - `txd`=1 for `STOP_BITS` x `CLKS_PER_BIT` cycles.
  - At the final boundary, `done`<=1 for one cycle.
  - If `en`=1 and `Fempty`=0 at that edge, go directly to FETCH with `Ren`<=1 (back-to-back frames). Otherwise go to IDLE.
- `Ren` is never asserted while `Fempty`=1 is sampled. Exactly one `Ren` pulse occurs per frame.
- `en` dropping mid-frame: the current frame completes, then the block goes to IDLE.
- Reset (`rst`=0 at any edge, including mid-frame)
  - State <= IDLE; `txd`<=1, `Ren`<=0, `busy`<=0, `done`<=0; counters cleared.
  - A byte already popped is discarded; no partial frame resumes.

## Timing
- Let E0 be the edge where IDLE samples `en`=1, `Fempty`=0. With C = `CLKS_PER_BIT`:
  - `Ren`=1 during (E0, E1].
  - The FIFO updates `Dout` at E1.
  - `txd` falls at E2.
  - Data bit i begins at E2+(i+1)C.
  - Parity (if enabled) begins at E2+9C.
  - Stop begins at E2+9C, or E2+10C with parity.
  - `done` rises at the frame end F = E2+(10+P+S-1)C, where P = 1 if parity is enabled else 0, and S = `STOP_BITS`.
- Back-to-back frame period is (10+P+S-1)C+2 cycles.
- `busy` rises at E0 and falls at F when the block returns to IDLE.

## Test plan
- Reset hold
  - Stimulus: `rst`=0 for 3 cycles with `Fempty`=0.
  - Required: `txd`=1, `Ren`=0, `busy`=0, `done`=0 throughout; first `Ren` is 1 cycle after `rst` rises.
- Single byte
  - Stimulus: `CLKS_PER_BIT`=4, no parity, 1 stop bit; FIFO holds 0xA5.
  - Required: `txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; `done` pulses once at E2+40; exactly one `Ren` pulse.
- Back-to-back
  - Stimulus: FIFO holds 0x00, 0xFF, 0x3C.
  - Required: three frames with correct bits; idle gap high of exactly 2 cycles between frames (FETCH and LATCH); 3 `Ren` pulses; block returns to IDLE with `Fempty`=1.
- Parity and stop bits
  - Stimulus: `PARITY`=2, `STOP_BITS`=2; byte 0x07.
  - Required: parity bit = 0; 2C-cycle stop; `done` at E2+12C.
- `en` toggling
  - Stimulus: `en` dropped during DATA with FIFO non-empty.
  - Required: the frame completes; no further `Ren` until `en`=1 again.
- Reset mid-frame
  - Stimulus: `rst`=0 during DATA bit 3.
  - Required: `txd`=1 at the next edge; `busy`=0; after release, the next FIFO byte is sent as a fresh full frame.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Purpose: drains a 16x8 synchronous FIFO and serializes each byte as an async UART frame
//          (start, 8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits).
// Latency: txd falls 2 cycles after the edge that samples en=1/Fempty=0; the frame then runs
//          (10+P+S-1)*CLKS_PER_BIT cycles, and back-to-back frames are separated by exactly 2 idle-high cycles.
// Backpressure: pops only when enabled and the FIFO reports non-empty; one Ren pulse per frame;
//          clearing en only stops the next fetch and never cuts a frame short.
// Ports:
//   ck     - clock, all state changes on posedge
//   rst    - synchronous active-low reset
//   en     - permits starting a new fetch
//   Fempty - registered FIFO empty flag
//   Dout   - FIFO read data, valid from the posedge after a sampled Ren
//   Ren    - registered one-cycle FIFO read strobe
//   txd    - registered serial output, idles high
//   busy   - high in every state except IDLE
//   done   - one-cycle pulse at the end of each frame's last stop bit
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       ck,
   input  logic       rst,
   input  logic       en,
   input  logic       Fempty,
   input  logic [7:0] Dout,
   output logic       Ren,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam logic [15:0] TMAX      = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
   localparam bit          PAR_EN    = (PARITY != 0);
   localparam bit          PAR_ODD   = (PARITY == 2);

   state_t      state, state_nxt;
   logic [15:0] timer, timer_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [7:0]  shreg, shreg_nxt;
   logic        par_acc, par_acc_nxt;
   logic        txd_nxt, ren_nxt, busy_nxt, done_nxt;
   logic        bit_end;

   always_ff @(posedge ck) begin
      if (!rst) begin
         state   <= ST_IDLE;
         timer   <= '0;
         idx     <= '0;
         shreg   <= '0;
         par_acc <= 1'b0;
         txd     <= 1'b1;
         Ren     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         idx     <= idx_nxt;
         shreg   <= shreg_nxt;
         par_acc <= par_acc_nxt;
         txd     <= txd_nxt;
         Ren     <= ren_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      idx_nxt     = idx;
      shreg_nxt   = shreg;
      par_acc_nxt = par_acc;
      txd_nxt     = txd;
      ren_nxt     = 1'b0;
      done_nxt    = 1'b0;
      bit_end     = (timer == TMAX);

      case (state)
         ST_IDLE: begin
            txd_nxt = 1'b1;
            if (en && !Fempty) begin
               state_nxt = ST_FETCH;
               ren_nxt   = 1'b1;
            end
         end

         // FIFO pops at the edge leaving this state.
         ST_FETCH: begin
            state_nxt = ST_LATCH;
         end

         // Dout has settled by the end of this cycle.
         ST_LATCH: begin
            shreg_nxt   = Dout;
            par_acc_nxt = ^Dout;
            txd_nxt     = 1'b0;
            timer_nxt   = '0;
            state_nxt   = ST_START;
         end

         ST_START: begin
            if (bit_end) begin
               timer_nxt = '0;
               idx_nxt   = '0;
               txd_nxt   = shreg[0];
               shreg_nxt = shreg >> 1;
               state_nxt = ST_DATA;
            end else begin
               timer_nxt = timer + 16'd1;
            end
         end

         // shreg[0] always holds the next data bit to drive.
         ST_DATA: begin
            if (bit_end) begin
               timer_nxt = '0;
               if (idx == 3'd7) begin
                  idx_nxt = '0;
                  if (PAR_EN) begin
                     txd_nxt   = par_acc ^ PAR_ODD;
                     state_nxt = ST_PARITY;
                  end else begin
                     txd_nxt   = 1'b1;
                     state_nxt = ST_STOP;
                  end
               end else begin
                  idx_nxt   = idx + 3'd1;
                  txd_nxt   = shreg[0];
                  shreg_nxt = shreg >> 1;
               end
            end else begin
               timer_nxt = timer + 16'd1;
            end
         end

         ST_PARITY: begin
            if (bit_end) begin
               timer_nxt = '0;
               idx_nxt   = '0;
               txd_nxt   = 1'b1;
               state_nxt = ST_STOP;
            end else begin
               timer_nxt = timer + 16'd1;
            end
         end

         // idx counts stop bits; txd stays high into FETCH/LATCH of a following frame.
         ST_STOP: begin
            if (bit_end) begin
               timer_nxt = '0;
               if (idx == STOP_LAST) begin
                  idx_nxt  = '0;
                  done_nxt = 1'b1;
                  if (en && !Fempty) begin
                     state_nxt = ST_FETCH;
                     ren_nxt   = 1'b1;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end else begin
               timer_nxt = timer + 16'd1;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            txd_nxt   = 1'b1;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Purpose: self-checking bench for fifo_uart_tx with behavioural FIFO models on the read side.
// Latency: instance A (C=4, no parity, 1 stop) frames are decoded by a monitor against a byte scoreboard;
//          instance B (C=4, odd parity, 2 stops) is checked cycle by cycle for one frame.
// Backpressure: en gating, Fempty gating and mid-frame reset are exercised in directed steps.
module tb_fifo_uart_tx;

   localparam int C       = 4;
   localparam int FRAME_A = (10 + 0 + 1 - 1) * C;
   localparam int PERIOD_A = FRAME_A + 2;
   localparam int FRAME_B = (10 + 1 + 2 - 1) * C;

   logic       ck = 1'b0;
   logic       rst;
   logic       en;

   logic       fempty_a = 1'b1;
   logic [7:0] dout_a   = 8'h00;
   logic       ren_a, txd_a, busy_a, done_a;

   logic       fempty_b = 1'b1;
   logic [7:0] dout_b   = 8'h00;
   logic       ren_b, txd_b, busy_b, done_b;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int ren_cnt_a = 0, done_cnt_a = 0, underflow_a = 0, aborts_a = 0;
   int ren_cnt_b = 0, done_cnt_b = 0, underflow_b = 0;

   logic [7:0] fq_a[$];
   logic [7:0] exp_q_a[$];
   logic [7:0] fq_b[$];
   int         start_q_a[$];

   fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u_a (
      .ck(ck), .rst(rst), .en(en), .Fempty(fempty_a), .Dout(dout_a),
      .Ren(ren_a), .txd(txd_a), .busy(busy_a), .done(done_a)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(2)) u_b (
      .ck(ck), .rst(rst), .en(en), .Fempty(fempty_b), .Dout(dout_b),
      .Ren(ren_b), .txd(txd_b), .busy(busy_b), .done(done_b)
   );

   always #5 ck = ~ck;

   always @(posedge ck) cyc <= cyc + 1;

   // FIFO models: registered empty flag, Dout updated at the edge that samples Ren.
   always @(posedge ck) begin
      if (ren_a === 1'b1) begin
         if (fq_a.size() > 0) dout_a <= fq_a.pop_front();
         else underflow_a <= underflow_a + 1;
      end
      fempty_a <= (fq_a.size() == 0);
   end

   always @(posedge ck) begin
      if (ren_b === 1'b1) begin
         if (fq_b.size() > 0) dout_b <= fq_b.pop_front();
         else underflow_b <= underflow_b + 1;
      end
      fempty_b <= (fq_b.size() == 0);
   end

   always @(negedge ck) begin
      if (ren_a === 1'b1)  ren_cnt_a  <= ren_cnt_a + 1;
      if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
      if (ren_b === 1'b1)  ren_cnt_b  <= ren_cnt_b + 1;
      if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_a(input logic [7:0] b);
      fq_a.push_back(b);
      exp_q_a.push_back(b);
   endtask

   // Decodes one frame of instance A starting at the negedge where txd was first seen low.
   task automatic rx_frame_a();
      logic [9:0] bits;
      logic       cur;
      logic       stable;
      logic [7:0] exp;
      bits   = '0;
      cur    = 1'b0;
      stable = 1'b1;
      start_q_a.push_back(cyc);
      if (exp_q_a.size() > 0) exp = exp_q_a.pop_front();
      else exp = 'x;
      for (int n = 0; n <= FRAME_A; n++) begin
         if (n > 0) @(negedge ck);
         if (rst !== 1'b1) begin
            aborts_a++;
            return;
         end
         if (n < FRAME_A) begin
            if (n % C == 0) begin
               cur  = txd_a;
               bits = {txd_a, bits[9:1]};
            end else if (txd_a !== cur) begin
               stable = 1'b0;
            end
            if (done_a !== 1'b0) stable = 1'b0;
         end
      end
      check("a_start_bit", bits[0], 1'b0);
      check("a_data", bits[8:1], exp);
      check("a_stop_bit", bits[9], 1'b1);
      check("a_bit_stable_no_early_done", stable, 1'b1);
      check("a_done_at_frame_end", done_a, 1'b1);
   endtask

   initial begin : mon_a
      logic prev;
      prev = 1'b1;
      forever begin
         @(negedge ck);
         if (rst === 1'b1 && prev === 1'b1 && txd_a === 1'b0) begin
            rx_frame_a();
            prev = 1'b1;
         end else begin
            prev = txd_a;
         end
      end
   end

   task automatic wait_done_a(input int target, input int limit);
      int k;
      k = 0;
      while (done_cnt_a < target && k < limit) begin
         @(negedge ck);
         k++;
      end
      check("a_done_count", done_cnt_a, target);
   endtask

   task automatic wait_start_a(input int target, input int limit);
      int k;
      k = 0;
      while (start_q_a.size() < target && k < limit) begin
         @(negedge ck);
         k++;
      end
      check("a_frame_started", start_q_a.size(), target);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [11:0] exp_b;
      logic        cur_b;
      logic [7:0]  byte_b;
      int          k;

      rst = 1'b0;
      en  = 1'b1;
      push_a(8'hA5);

      // Reset hold with a non-empty FIFO.
      for (int i = 0; i < 3; i++) begin
         @(negedge ck);
         check("rst_txd", txd_a, 1'b1);
         check("rst_ren", ren_a, 1'b0);
         check("rst_busy", busy_a, 1'b0);
         check("rst_done", done_a, 1'b0);
      end
      rst = 1'b1;
      @(negedge ck);
      check("first_ren_after_rst", ren_a, 1'b1);
      check("busy_at_fetch", busy_a, 1'b1);

      // Single byte 0xA5.
      wait_done_a(1, 200);
      check("single_ren_count", ren_cnt_a, 1);
      check("single_idle_busy", busy_a, 1'b0);
      check("single_idle_txd", txd_a, 1'b1);

      // Back-to-back frames.
      push_a(8'h00);
      push_a(8'hFF);
      push_a(8'h3C);
      wait_done_a(4, 600);
      @(negedge ck);
      check("b2b_ren_count", ren_cnt_a, 4);
      check("b2b_idle_busy", busy_a, 1'b0);
      check("b2b_fifo_empty", fempty_a, 1'b1);
      check("b2b_frames", start_q_a.size(), 4);
      if (start_q_a.size() >= 4) begin
         check("b2b_period_1", start_q_a[2] - start_q_a[1], PERIOD_A);
         check("b2b_period_2", start_q_a[3] - start_q_a[2], PERIOD_A);
      end

      // en gating: no fetch while low, frame in progress completes when dropped.
      en = 1'b0;
      push_a(8'h5A);
      push_a(8'h81);
      repeat (6) @(negedge ck);
      check("en_low_no_ren", ren_cnt_a, 4);
      check("en_low_idle", busy_a, 1'b0);
      en = 1'b1;
      wait_start_a(5, 50);
      repeat (9) @(negedge ck);
      en = 1'b0;
      wait_done_a(5, 200);
      repeat (60) @(negedge ck);
      check("en_drop_ren_count", ren_cnt_a, 5);
      check("en_drop_idle_busy", busy_a, 1'b0);
      check("en_drop_txd", txd_a, 1'b1);
      check("en_drop_fifo_nonempty", fempty_a, 1'b0);
      en = 1'b1;
      wait_done_a(6, 200);
      check("en_resume_ren_count", ren_cnt_a, 6);

      // Reset in data bit 3; the popped byte is discarded.
      push_a(8'h96);
      push_a(8'h4B);
      wait_start_a(7, 50);
      repeat (17) @(negedge ck);
      rst = 1'b0;
      @(negedge ck);
      check("midrst_txd", txd_a, 1'b1);
      check("midrst_busy", busy_a, 1'b0);
      check("midrst_ren", ren_a, 1'b0);
      check("midrst_done", done_a, 1'b0);
      @(negedge ck);
      rst = 1'b1;
      wait_done_a(7, 200);
      @(negedge ck);
      check("midrst_aborts", aborts_a, 1);
      check("midrst_ren_count", ren_cnt_a, 8);
      check("midrst_frames", start_q_a.size(), 8);
      check("a_scoreboard_drained", exp_q_a.size(), 0);
      check("a_no_underflow", underflow_a, 0);

      // Instance B: odd parity, 2 stop bits, byte 0x07.
      byte_b = 8'h07;
      exp_b  = {1'b1, 1'b1, ~(^byte_b), byte_b, 1'b0};
      fq_b.push_back(byte_b);
      k = 0;
      while (txd_b !== 1'b0 && k < 30) begin
         @(negedge ck);
         k++;
      end
      check("b_start_seen", txd_b, 1'b0);
      cur_b = 1'b0;
      for (int n = 0; n <= FRAME_B; n++) begin
         if (n > 0) @(negedge ck);
         if (n < FRAME_B) begin
            if (n % C == 0) begin
               cur_b = exp_b[0];
               exp_b = exp_b >> 1;
            end
            check("b_txd", txd_b, cur_b);
         end
         if (n == FRAME_B - 1) check("b_no_early_done", done_b, 1'b0);
         if (n == FRAME_B) check("b_done_at_frame_end", done_b, 1'b1);
      end
      repeat (3) @(negedge ck);
      check("b_ren_count", ren_cnt_b, 1);
      check("b_done_count", done_cnt_b, 1);
      check("b_idle_busy", busy_b, 1'b0);
      check("b_no_underflow", underflow_b, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
